// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small input FIFO; frames leave LSB first at CLKS_PER_BIT clocks per bit.
// Handshake: a byte transfers on a rising edge where valid_i && ready_o; data_i is sampled only at that edge.
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [DATA_WIDTH-1:0]         data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          tx_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic [1:0]                    state_o
);

    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] LAST_BAUD = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    state_t                r_state;
    logic                  r_tx;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_baud_done;
    logic [DATA_WIDTH-1:0] w_head;

    assign w_baud_done = (r_baud == LAST_BAUD);
    assign w_push      = valid_i && ready_o;
    // The FSM takes the head either from idle or at the very end of a stop bit, so frames chain with no gap.
    assign w_pop       = (r_count != '0) &&
                         ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_done));
    assign w_head      = r_mem[r_rd_ptr];

    assign ready_o = (r_count != FULL_CNT);
    assign tx_o    = r_tx;
    assign busy_o  = (r_state != ST_IDLE) || (r_count != '0);
    assign count_o = r_count;
    assign state_o = r_state;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_baud <= '0;
                    r_bit  <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_baud_done) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                        r_shift <= r_shift >> 1;
                        r_state <= ST_DATA;
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_DATA: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (r_bit == LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_bit   <= r_bit + BIT_W'(1);
                            r_tx    <= r_shift[0];
                            r_shift <= r_shift >> 1;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                ST_STOP: begin
                    if (w_baud_done) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= ST_START;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + BAUD_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a serial line decoder checks every frame against a queue of accepted bytes.
module tb_uart_tx;

    localparam int CPB   = 16;
    localparam int DW    = 8;
    localparam int FD    = 4;
    localparam int CW    = $clog2(FD) + 1;
    localparam int FRAME = (DW + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [DW-1:0] data_i = '0;
    logic          valid_i = 1'b0;
    logic          ready_o;
    logic          tx_o;
    logic          busy_o;
    logic [CW-1:0] count_o;
    logic [1:0]    state_o;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o),
        .count_o (count_o),
        .state_o (state_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Scoreboard: bytes in accept order; the line decoder consumes them frame by frame.
    logic [DW-1:0] exp_q[$];
    int            start_q[$];
    int            frames = 0;
    bit            in_frame = 0;
    int            idx = 0;
    logic [DW-1:0] rx_byte = '0;

    always @(negedge clk) begin
        if (reset_i) begin
            in_frame = 0;
        end else if (!in_frame) begin
            if (tx_o == 1'b0) begin
                in_frame = 1;
                idx = 0;
                start_q.push_back(cyc);
            end
        end else begin
            idx++;
            if (idx % CPB == CPB / 2) begin
                int j;
                j = idx / CPB;
                if (j == 0) begin
                    check("start_bit", 32'(tx_o), 0);
                end else if (j <= DW) begin
                    rx_byte[j-1] = tx_o;
                end else begin
                    check("stop_bit", 32'(tx_o), 1);
                    frames++;
                    in_frame = 0;
                    if (exp_q.size() == 0) begin
                        check("frame_without_push", 32'(exp_q.size()), 1);
                    end else begin
                        check("frame_data", 32'(rx_byte), 32'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offers b until accepted; stalls counts negedges seen with ready_o low.
    task automatic push(input logic [DW-1:0] b, input bit hold, input bit chk_stall, output int stalls);
        int t;
        bit ok;
        t = 0;
        ok = 0;
        stalls = 0;
        data_i = b;
        valid_i = 1'b1;
        while (t < 2000) begin
            @(negedge clk);
            if (ready_o) begin
                ok = 1;
                break;
            end
            stalls++;
            if (chk_stall) check("stall_count", 32'(count_o), FD);
            t++;
        end
        if (!ok) begin
            check("push_timeout", 32'(ready_o), 1);
            valid_i = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            exp_q.push_back(b);
            if (!hold) valid_i = 1'b0;
        end
    endtask

    task automatic wait_idle(input int bound);
        int t;
        t = 0;
        while (t < bound) begin
            @(negedge clk);
            if (!busy_o) break;
            t++;
        end
        if (t >= bound) check("drain_timeout", 32'(busy_o), 0);
        tick(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int n0;
        int f0;
        logic [DW-1:0] burst [5];
        logic [DW-1:0] r;
        logic [DW+1:0] fbits;

        // Reset and idle hold
        reset_i = 1'b1;
        tick(3);
        reset_i = 1'b0;
        check("rst_tx", 32'(tx_o), 1);
        check("rst_ready", 32'(ready_o), 1);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_count", 32'(count_o), 0);
        for (int k = 0; k < 100; k++) begin
            check("idle_tx", 32'(tx_o), 1);
            check("idle_ready", 32'(ready_o), 1);
            check("idle_busy", 32'(busy_o), 0);
            check("idle_count", 32'(count_o), 0);
            tick(1);
        end

        // Single frame of 0x55: exact bit-by-bit line image
        push(8'h55, 0, 0, st);
        check("s2_count_after_accept", 32'(count_o), 1);
        check("s2_busy_after_accept", 32'(busy_o), 1);
        check("s2_tx_still_idle", 32'(tx_o), 1);
        tick(1);
        check("s2_count_after_pop", 32'(count_o), 0);
        fbits = {1'b1, 8'h55, 1'b0};
        for (int k = 0; k < FRAME; k++) begin
            check("s2_line", 32'(tx_o), 32'(fbits[k / CPB]));
            check("s2_busy_in_frame", 32'(busy_o), 1);
            tick(1);
        end
        check("s2_busy_after_frame", 32'(busy_o), 0);
        check("s2_tx_after_frame", 32'(tx_o), 1);
        tick(5);
        check("s2_loopback_count", 32'(frames), 1);

        // Burst of five with valid held: four buffered, zero-gap frames
        burst[0] = 8'hAA; burst[1] = 8'hF0; burst[2] = 8'h01; burst[3] = 8'h80; burst[4] = 8'h3C;
        n0 = start_q.size();
        for (int i = 0; i < 5; i++) push(burst[i], (i < 4), 0, st);
        check("s3_count_full", 32'(count_o), FD);
        check("s3_ready_low", 32'(ready_o), 0);
        wait_idle(2000);
        check("s3_frames", 32'(start_q.size() - n0), 5);
        if (start_q.size() - n0 == 5) begin
            for (int i = 0; i < 4; i++)
                check("s3_gap", 32'(start_q[n0+i+1] - start_q[n0+i]), FRAME);
            check("s3_total", 32'(start_q[n0+4] + FRAME - start_q[n0]), 5 * FRAME);
        end
        check("s3_queue_empty", 32'(exp_q.size()), 0);

        // Hold 0xFF against a full FIFO
        f0 = frames;
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)), 1, 0, st);
        push(8'hFF, 0, 1, st);
        check("s4_stall_cycles", 32'(st), FRAME - 3);
        check("s4_count_after_accept", 32'(count_o), FD);
        wait_idle(2000);
        check("s4_frames", 32'(frames - f0), 6);
        check("s4_queue_empty", 32'(exp_q.size()), 0);

        // Reset in the middle of 0xF0's data bits with two bytes queued
        push(8'hF0, 0, 0, st);
        push(8'($urandom_range(0, 255)), 0, 0, st);
        push(8'($urandom_range(0, 255)), 0, 0, st);
        check("s5_count_queued", 32'(count_o), 2);
        tick(60);
        f0 = frames;
        reset_i = 1'b1;
        valid_i = 1'b1;
        data_i = 8'hA5;
        tick(1);
        reset_i = 1'b0;
        valid_i = 1'b0;
        exp_q.delete();
        check("s5_tx", 32'(tx_o), 1);
        check("s5_count", 32'(count_o), 0);
        check("s5_busy", 32'(busy_o), 0);
        check("s5_ready", 32'(ready_o), 1);
        for (int k = 0; k < 3 * FRAME; k++) begin
            check("s5_line_quiet", 32'(tx_o), 1);
            tick(1);
        end
        check("s5_no_frames", 32'(frames - f0), 0);
        check("s5_count_later", 32'(count_o), 0);

        // data_i changes right after the accept edge
        r = 8'($urandom_range(0, 255));
        f0 = frames;
        push(r, 0, 0, st);
        data_i = ~r;
        wait_idle(2000);
        check("s6_frames", 32'(frames - f0), 1);
        check("s6_queue_empty", 32'(exp_q.size()), 0);

        // Randomised traffic with random gaps
        f0 = frames;
        for (int i = 0; i < 24; i++) begin
            push(8'($urandom_range(0, 255)), 0, 0, st);
            data_i = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 200));
        end
        wait_idle(8000);
        check("rand_frames", 32'(frames - f0), 24);
        check("rand_queue_empty", 32'(exp_q.size()), 0);
        check("final_tx", 32'(tx_o), 1);
        check("final_count", 32'(count_o), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
UART transmitter for the return path of the UART ALU design. It serialises result bytes from the ALU core onto the tx line using 8N1 framing: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. A small input FIFO lets the core push a multi-byte response back-to-back while the line drains at the bit rate. The bit timing matches the receive side, so the block can be looped back against the existing receiver and the bench's serial model.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200 baud); must be >= 2.
- DATA_WIDTH, 8: bits per frame.
- FIFO_DEPTH, 4: input FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  system clock, all logic on rising edge
- reset_i  input  1  synchronous reset, active-high
- data_i  input  DATA_WIDTH  byte to transmit
- valid_i  input  1  data_i valid
- ready_o  output  1  FIFO can accept; a transfer occurs on a rising edge with valid_i && ready_o
- tx_o  output  1  serial line, idle high, registered output
- busy_o  output  1  FIFO non-empty or frame in progress
- count_o  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - While reset_i is high at an edge: tx_o=1, ready_o=1 (after that edge), busy_o=0, count_o=0, FSM=IDLE, FIFO pointers cleared, bit and baud counters=0.
- FIFO:
  - ready_o = (count != FIFO_DEPTH), combinational from the registered count.
  - Push on valid_i && ready_o; data_i is captured at that edge, and later changes to data_i have no effect.
  - valid_i while ready_o=0 is ignored: no capture, no overflow, count unchanged.
  - Push and pop in the same cycle: count unchanged, both take effect.
  - Pointers wrap modulo FIFO_DEPTH.
  - Bytes are transmitted in strict push order.
- FSM states: IDLE, START, DATA, STOP. The baud counter counts 0..CLKS_PER_BIT-1 within each bit.
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into the shift register, set tx_o=0 and go to START (registered, same edge).
  - START: hold tx_o=0 for CLKS_PER_BIT cycles, then drive bit 0 and go to DATA.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit DATA_WIDTH-1 completes, set tx_o=1 and go to STOP.
  - STOP: hold tx_o=1 for CLKS_PER_BIT cycles. At the end:
    - if the FIFO is non-empty, pop and enter START directly (no idle gap);
    - otherwise go to IDLE.
- Timing:
  - Latency: with the FSM in IDLE and the FIFO empty, a byte accepted at edge E gives count=1 after E. The pop occurs at edge E+1, so tx_o falls at E+1.
  - Frame length is exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames have zero idle cycles between the stop bit and the next start bit.
  - Throughput: the FIFO sustains one byte per frame. Bursts up to FIFO_DEPTH are accepted with ready_o high, plus one more once the first pop has happened.
- busy_o = (state != IDLE) || (count != 0). It rises the cycle after the first accept and falls the cycle after the final stop bit completes with the FIFO empty.
- Reset mid-frame: the frame is abandoned and buffered bytes are discarded. tx_o is high after the reset edge. A valid_i asserted during reset is not captured.
- tx_o has no glitches: it changes only on clock edges at bit boundaries.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and FIFO_DEPTH=4.
1. Reset, then hold idle for 100 cycles -> tx_o=1, ready_o=1, busy_o=0, count_o=0 throughout.
2. Push 8'h55 once -> tx_o falls 1 cycle after the accept edge and shows the bit sequence 0,1,0,1,0,1,0,1,0,1 at 16 cycles per bit. The total frame is 160 cycles, busy_o falls 1 cycle after the frame, and a loopback into the existing UART receiver returns 8'h55.
3. Burst-push 8'hAA, 8'hF0, 8'h01, 8'h80, 8'h3C with valid_i held high -> the first 5 pushes are accepted and ready_o drops with count_o=4. All 5 frames go out in order with no idle cycle between stop and start, 800 cycles total.
4. Hold valid_i with 8'hFF while the FIFO is full -> no capture while ready_o=0. The push completes on the first edge with ready_o=1, and exactly one 8'hFF frame is sent for that transfer.
5. Assert reset_i for 1 cycle midway through the DATA bits of 8'hF0 with 2 bytes queued -> tx_o=1 on the next edge, count_o=0, busy_o=0, and no further frames are sent.
6. Change data_i on the cycle after the accept edge -> the transmitted frame carries the originally accepted value.
